// File: rtl/cache_mem_ctrl_pkg.sv
// Shared types and constants for the cache miss / memory controller.
package cache_mem_ctrl_pkg;

    // Byte-offset bits inside a cache block (16-byte blocks).
    localparam int unsigned BLK_OFF_BITS = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WB    = 3'd1,
        FILL  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_e;

    // Beat counter width for a block of n words (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_beat_seq.sv
// Word-serial beat sequencer: owns the beat counter, holds mem_req until
// mem_ready, and flags the last beat of a block.
module mem_beat_seq
    import cache_mem_ctrl_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic                             run,
    input  logic                             mem_ready,
    output logic                             mem_req,
    output logic [cnt_width(BLOCK_SIZE)-1:0] beat_cnt,
    output logic                             beat_done_c,
    output logic                             last_beat_c,
    output logic [cnt_width(BLOCK_SIZE)-1:0] cnt_next_c,
    output logic                             req_next_c
);

    localparam int unsigned CNT_W = cnt_width(BLOCK_SIZE);

    logic [CNT_W-1:0] cnt_q;

    assign beat_cnt = cnt_q;

    // Beat completion, last-beat detect and next counter/request values.
    always_comb begin
        beat_done_c = mem_req && mem_ready;
        last_beat_c = beat_done_c && (cnt_q == CNT_W'(BLOCK_SIZE - 1));
        cnt_next_c  = cnt_q;
        req_next_c  = mem_req;
        if (clear) begin
            cnt_next_c = '0;
            req_next_c = 1'b0;
        end else if (beat_done_c) begin
            if (last_beat_c) begin
                req_next_c = 1'b0;
            end else begin
                cnt_next_c = cnt_q + CNT_W'(1);
            end
        end else if (run && !mem_req) begin
            req_next_c = 1'b1;
        end
    end

    // Counter and request hold register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            mem_req <= 1'b0;
        end else begin
            cnt_q   <= cnt_next_c;
            mem_req <= req_next_c;
        end
    end

endmodule

// File: rtl/cache_mem_ctrl.sv
// Cache miss controller: optional victim write-back plus block refill over a
// word-serial memory port. Build macro WB_BUFFER_EN refills first and drains
// the buffered victim afterwards without stalling the pipeline.
module cache_mem_ctrl
    import cache_mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BLOCK_SIZE = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [DATA_WIDTH-1:0]            req_addr,
    input  logic                             wb_valid,
    input  logic [DATA_WIDTH-1:0]            wb_addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] wb_data,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] fetch_data,
    output logic                             fetch_enable,
    output logic                             busy,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [DATA_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic                             mem_ready,
    input  logic [DATA_WIDTH-1:0]            mem_rdata
);

    localparam int unsigned CNT_W = cnt_width(BLOCK_SIZE);
    localparam logic [DATA_WIDTH-1:0] BLK_MASK = ~DATA_WIDTH'((1 << BLK_OFF_BITS) - 1);

    state_e                state_q, state_next_c;
    logic [DATA_WIDTH-1:0] req_addr_q, wb_addr_q, base_c;
    logic [DATA_WIDTH-1:0] wb_words_q [BLOCK_SIZE];
    logic [DATA_WIDTH-1:0] fetch_q    [BLOCK_SIZE];
    logic [CNT_W-1:0]      beat_cnt, cnt_next_c;
    logic                  beat_done_c, last_beat_c, req_next_c, accept_c, run_c, clear_c;
`ifdef WB_BUFFER_EN
    logic                  wb_valid_q;
`endif

    assign accept_c = req_valid && req_ready;
    assign run_c    = (state_q == WB) || (state_q == FILL) || (state_q == DRAIN);
    assign clear_c  = (state_next_c != state_q);
    assign base_c   = (state_q == FILL) ? req_addr_q : wb_addr_q;

    mem_beat_seq #(.BLOCK_SIZE(BLOCK_SIZE)) u_seq (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear_c),
        .run         (run_c),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .beat_cnt    (beat_cnt),
        .beat_done_c (beat_done_c),
        .last_beat_c (last_beat_c),
        .cnt_next_c  (cnt_next_c),
        .req_next_c  (req_next_c)
    );

    // Next-state logic.
    always_comb begin
        state_next_c = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
`ifdef WB_BUFFER_EN
                    state_next_c = FILL;
`else
                    state_next_c = wb_valid ? WB : FILL;
`endif
                end
            end
            WB:   if (last_beat_c) state_next_c = FILL;
            FILL: if (last_beat_c) state_next_c = DONE;
`ifdef WB_BUFFER_EN
            DONE:  state_next_c = wb_valid_q ? DRAIN : IDLE;
            DRAIN: if (last_beat_c) state_next_c = IDLE;
`else
            DONE:  state_next_c = IDLE;
`endif
            default: state_next_c = IDLE;
        endcase
    end

    // State register and state-derived handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            fetch_enable <= 1'b0;
        end else begin
            state_q      <= state_next_c;
            req_ready    <= (state_next_c == IDLE);
            busy         <= (state_next_c == WB) || (state_next_c == FILL) || (state_next_c == DONE);
            fetch_enable <= (state_next_c == DONE);
        end
    end

    // Request capture on accept; block addresses are aligned to the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr_q <= '0;
            wb_addr_q  <= '0;
            for (int unsigned i = 0; i < BLOCK_SIZE; i++) wb_words_q[i] <= '0;
`ifdef WB_BUFFER_EN
            wb_valid_q <= 1'b0;
`endif
        end else if (accept_c) begin
            req_addr_q <= req_addr & BLK_MASK;
            wb_addr_q  <= wb_addr & BLK_MASK;
            for (int unsigned i = 0; i < BLOCK_SIZE; i++)
                wb_words_q[i] <= wb_data[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef WB_BUFFER_EN
            wb_valid_q <= wb_valid;
        end else if (state_q == DRAIN && last_beat_c) begin
            wb_valid_q <= 1'b0;
`endif
        end
    end

    // Memory beat address/data; loaded for the upcoming beat so they stay
    // stable for as long as mem_req waits on mem_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (req_next_c) begin
            mem_we    <= (state_q != FILL);
            mem_addr  <= base_c + (DATA_WIDTH'(cnt_next_c) << 2);
            mem_wdata <= (state_q == FILL) ? '0 : wb_words_q[cnt_next_c];
        end else begin
            mem_we    <= 1'b0;
        end
    end

    // Refill data capture; holds outside FILL.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BLOCK_SIZE; i++) fetch_q[i] <= '0;
        end else if (state_q == FILL && beat_done_c) begin
            fetch_q[beat_cnt] <= mem_rdata;
        end
    end

    // Pack refill words onto the output bus.
    always_comb begin
        fetch_data = '0;
        for (int unsigned i = 0; i < BLOCK_SIZE; i++)
            fetch_data[i*DATA_WIDTH +: DATA_WIDTH] = fetch_q[i];
    end

endmodule

// File: doc/cache_mem_ctrl.md
CACHE_MEM_CTRL -- requirements
Module: cache_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning word width in bits.
REQ-002 SHALL have parameter BLOCK_SIZE, default 4, meaning words per cache block.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  cache miss request.
REQ-006 SHALL have port req_ready  output  1  controller can accept a request.
REQ-007 SHALL have port req_addr  input  DATA_WIDTH  miss address; bits [3:0] ignored.
REQ-008 SHALL have port wb_valid  input  1  victim block dirty; sampled with the request.
REQ-009 SHALL have port wb_addr  input  DATA_WIDTH  victim block base address.
REQ-010 SHALL have port wb_data  input  BLOCK_SIZE*DATA_WIDTH  victim block; word i at bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH].
REQ-011 SHALL have port fetch_data  output  BLOCK_SIZE*DATA_WIDTH  refilled block, same word packing.
REQ-012 SHALL have port fetch_enable  output  1  one-cycle pulse; fetch_data valid.
REQ-013 SHALL have port busy  output  1  pipeline stall request.
REQ-014 SHALL have ports mem_req (output 1), mem_we (output 1), mem_addr (output DATA_WIDTH), mem_wdata (output DATA_WIDTH), mem_ready (input 1), mem_rdata (input DATA_WIDTH): word-serial memory port.

Function
REQ-015 SHALL accept a request when req_valid && req_ready; on accept it latches req_addr & ~32'hF, wb_valid, wb_addr & ~32'hF, wb_data.
REQ-016 SHALL implement states IDLE, WB, FILL, DONE (plus DRAIN per REQ-028); req_ready = 1 only in IDLE.
REQ-017 IDLE: on accept go to WB if latched wb_valid, else FILL; otherwise stay.
REQ-018 Each memory beat: mem_req held high with mem_addr/mem_we/mem_wdata stable until mem_ready sampled high; beat completes on that edge.
REQ-019 Beat address = block base + 4*beat_cnt; beat_cnt 0..BLOCK_SIZE-1, cleared on every state entry.
REQ-020 WB: mem_we = 1, mem_wdata = latched word beat_cnt; after beat BLOCK_SIZE-1 completes, go to FILL.
REQ-021 FILL: mem_we = 0; on each completed beat store mem_rdata into word beat_cnt of fetch_data register; after last beat go to DONE.
REQ-022 DONE: fetch_enable = 1 for exactly this one cycle; fetch_data stable; next state IDLE.
REQ-023 mem_req SHALL drop in the cycle after the last beat of a state; no beat SHALL be issued in IDLE or DONE.
REQ-024 busy = 1 from the cycle after accept through DONE inclusive; 0 in IDLE.
REQ-025 mem_ready while mem_req = 0 SHALL be ignored; req_valid while not IDLE SHALL be ignored (not queued).
REQ-026 fetch_data SHALL hold its last value outside FILL.

Reset
REQ-027 rst high at a clock edge SHALL force IDLE, beat_cnt 0, fetch_enable 0, busy 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, fetch_data 0, latched request cleared; an in-progress transfer is abandoned (partial write-back not resumed).

Configuration
REQ-028 Macro WB_BUFFER_EN defined: accept goes to FILL first; victim held in buffer; DONE goes to DRAIN if buffered victim valid, DRAIN writes it out per REQ-020 then IDLE; busy = 0 during DRAIN; req_ready = 0 during DRAIN.
REQ-029 WB_BUFFER_EN undefined: write-back precedes fill per REQ-017; DRAIN state and buffer absent.

Structure
REQ-030 Shared package SHALL hold the state enum typedef (IDLE, WB, FILL, DONE, DRAIN) and block-offset constant (4 address bits).
REQ-031 One sub-module mem_beat_seq SHALL own beat_cnt, mem_req hold and last-beat detect; FSM and data registers stay in cache_mem_ctrl.

Verification
REQ-032 Clean miss, req_addr 0x0000_1234, mem_ready always 1 -> 4 reads at 0x1230..0x123C, fetch_enable pulse 6 cycles after accept, fetch_data = mem words in order.
REQ-033 Dirty miss, wb_addr 0x0000_2010, wb_data words 0xA0..0xA3 -> 4 writes 0x2010..0x201C data 0xA0..0xA3, then 4 reads; with WB_BUFFER_EN reads first, busy drops before writes.
REQ-034 mem_ready low 3 cycles per beat -> mem_addr/mem_wdata stable while waiting, beat count exactly 4, fetch_enable once.
REQ-035 rst asserted during beat 2 of WB -> next cycle mem_req 0, busy 0, req_ready 1; new request restarts at beat 0.
REQ-036 req_valid held high through a transfer -> second request accepted only on return to IDLE; none lost or duplicated.
